lrwait_bank_node: RTL and testbench
===================================

LRWAIT_BANK_NODE -- requirements
Module: lrwait_bank_node

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning request address width.
REQ-002 SHALL have parameter DataWidth, default 32, meaning data word width; byte strobe width is DataWidth/8.
REQ-003 SHALL have parameter metadata_t, default logic [4:0], meaning the opaque request/response ID type.
REQ-004 SHALL have parameter NumWaiters, default 4, meaning the LRWait wait-queue depth (>=1).
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
- clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
- tile_qaddr_i  in  AddrWidth  request byte address.
- tile_qwrite_i  in  1  store.
- tile_qamo_i  in  4  0=none, 4'hA=LR, 4'hB=SC.
- tile_qdata_i  in  DataWidth  store data; tile_qstrb_i  in  DataWidth/8  byte enables.
- tile_qid_i  in  metadata_t  requester ID.
- tile_qlrwait_i  in  1  LR is an LRWait.
- tile_qvalid_i  in  1 / tile_qready_o  out  1  request handshake.
- tile_pdata_o  out  DataWidth; tile_perror_o  out  1; tile_pid_o  out  metadata_t; tile_plrwait_o  out  1.
- tile_pvalid_o  out  1 / tile_pready_i  in  1  response handshake.
- mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  AddrWidth; mem_wdata_o  out  DataWidth; mem_be_o  out  DataWidth/8.
- mem_rdata_i  in  DataWidth  SRAM read data, valid exactly 1 cycle after mem_req_o.

Function
REQ-006 SHALL hold one reservation {res_valid, res_addr (word address bits [AddrWidth-1:2]), res_id} and a FIFO of NumWaiters IDs.
REQ-007 SHALL implement FSM states IDLE and WAKE; IDLE->WAKE when the reservation is released with queue non-empty; WAKE->IDLE when the wake read is issued.
REQ-008 SHALL drive tile_qready_o = (state==IDLE) && (!tile_pvalid_o || tile_pready_i).
REQ-009 SHALL, for an accepted plain load/store, issue mem_req_o in the accept cycle and assert tile_pvalid_o the next cycle (read: pdata = mem_rdata_i; write: pdata = 0), pid = qid, perror = 0, plrwait = 0.
REQ-010 SHALL, on a plain store whose word address equals res_addr, clear res_valid; enter WAKE if queue non-empty.
REQ-011 SHALL, on LR (qlrwait=0): if queue empty, read and set reservation {addr, qid}; if queue non-empty, respond perror=1 without memory access.
REQ-012 SHALL, on LRWait with res_valid=0, behave as REQ-011 grant and respond with plrwait=1.
REQ-013 SHALL, on LRWait with res_valid=1, matching address and queue not full, enqueue qid, issue no memory access and no response.
REQ-014 SHALL, on LRWait with address mismatch or queue full, respond next cycle with perror=1, plrwait=1, no memory access.
REQ-015 SHALL, on SC with res_valid, address match and qid==res_id, write memory, respond pdata=0, clear res_valid, enter WAKE if queue non-empty; otherwise no write, pdata=1, reservation unchanged.
REQ-016 SHALL treat any other tile_qamo_i value as error: respond perror=1, no memory access.
REQ-017 SHALL in WAKE, once the response slot is free, pop the queue head, issue a read of res_addr, set reservation {res_addr, head}, and respond next cycle with pid=head, plrwait=1, perror=0.
REQ-018 SHALL hold all tile_p* outputs stable while tile_pvalid_o && !tile_pready_i, including pdata captured from mem_rdata_i.
REQ-019 SHALL produce exactly one response per accepted request (deferred for enqueued LRWaits), in issue order except deferred ones.
REQ-020 SHALL keep FIFO order: waiters are woken oldest first; pointers wrap modulo NumWaiters.

Reset
REQ-021 SHALL on rst_i asynchronously set: state=IDLE, res_valid=0, queue empty, tile_pvalid_o=0, mem_req_o=0, mem_we_o=0, all other outputs 0.
REQ-022 SHALL discard pending waiters and the in-flight response on reset mid-operation; no response is emitted after reset release for pre-reset requests.

Verification
REQ-023 Store 0xDEADBEEF strb 4'hF to 0x100, then load 0x100 id 3 -> response pdata=0xDEADBEEF, pid=3, 1 cycle after accept.
REQ-024 LRWait id1 @0x40 (grant, plrwait=1); LRWait id2, id3 @0x40 -> no responses; SC id1 @0x40 data 7 -> pdata=0; next: WAKE response pid=2 pdata=7 plrwait=1; SC id2 -> pdata=0; then pid=3 woken.
REQ-025 With NumWaiters=4 and 4 queued, fifth LRWait @0x40 -> perror=1, plrwait=1; LRWait @0x80 while reserved @0x40 -> perror=1.
REQ-026 SC id5 @0x40 while res_id=1 -> pdata=1, memory unchanged; plain store @0x40 with waiter id2 queued -> reservation cleared, pid=2 woken, later SC id1 -> pdata=1.
REQ-027 Hold tile_pready_i=0 for 5 cycles on a read response -> outputs stable, tile_qready_o=0; release -> next request accepted same cycle.
REQ-028 Assert rst_i with 2 waiters queued and pvalid high -> all outputs 0 immediately; after release, LR id4 @0x40 grants normally with plrwait=0.

Source files
------------

// File: rtl/lrwait_bank_node.sv
// lrwait_bank_node
//   Single-bank memory node that serves plain loads/stores plus LR/SC and
//   LRWait atomics in front of a 1-cycle-latency SRAM. One reservation is
//   held. LRWait requests that hit an existing reservation are parked in a
//   FIFO of requester IDs and answered (with a fresh read) when the
//   reservation is released.
//
// Ports
//   clk_i, rst_i         clock; asynchronous active-high reset
//   tile_q*              request channel (valid/ready), amo: 0 none, A LR, B SC
//   tile_p*              response channel (valid/ready)
//   mem_*                SRAM port; mem_rdata_i valid 1 cycle after mem_req_o
module lrwait_bank_node #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter type         metadata_t = logic [4:0],
    parameter int unsigned NumWaiters = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   tile_qaddr_i,
    input  logic                   tile_qwrite_i,
    input  logic [3:0]             tile_qamo_i,
    input  logic [DataWidth-1:0]   tile_qdata_i,
    input  logic [DataWidth/8-1:0] tile_qstrb_i,
    input  metadata_t              tile_qid_i,
    input  logic                   tile_qlrwait_i,
    input  logic                   tile_qvalid_i,
    output logic                   tile_qready_o,
    output logic [DataWidth-1:0]   tile_pdata_o,
    output logic                   tile_perror_o,
    output metadata_t              tile_pid_o,
    output logic                   tile_plrwait_o,
    output logic                   tile_pvalid_o,
    input  logic                   tile_pready_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    localparam int unsigned WordWidth = AddrWidth - 2;
    localparam int unsigned PtrWidth  = (NumWaiters > 1) ? $clog2(NumWaiters) : 1;
    localparam int unsigned CntWidth  = $clog2(NumWaiters + 1);

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLr   = 4'hA;
    localparam logic [3:0] AmoSc   = 4'hB;

    typedef enum logic {
        IDLE,
        WAKE
    } state_e;

    state_e state_q, state_d;

    // Reservation
    logic                 res_valid_q, res_valid_d;
    logic [WordWidth-1:0] res_addr_q, res_addr_d;
    metadata_t            res_id_q, res_id_d;

    // Waiter FIFO
    metadata_t           wait_q [NumWaiters];
    logic [PtrWidth-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                push, pop;
    logic                q_empty, q_full;

    // Response slot. rsp_rd_q marks a read whose data is still on
    // mem_rdata_i and has not yet been captured into rsp_data_q.
    logic                 rsp_valid_q;
    metadata_t            rsp_id_q;
    logic                 rsp_err_q, rsp_lrwait_q, rsp_rd_q;
    logic [DataWidth-1:0] rsp_data_q;

    logic                 rsp_load;
    metadata_t            rsp_id_d;
    logic                 rsp_err_d, rsp_lrwait_d, rsp_rd_d;
    logic [DataWidth-1:0] rsp_data_d;

    logic                 slot_free, accept, release_res;
    logic [WordWidth-1:0] req_word;
    logic                 addr_match, res_hit;

    assign q_empty    = (count_q == '0);
    assign q_full     = (count_q == CntWidth'(NumWaiters));
    assign slot_free  = !rsp_valid_q || tile_pready_i;
    assign req_word   = tile_qaddr_i[AddrWidth-1:2];
    assign addr_match = (req_word == res_addr_q);
    assign res_hit    = res_valid_q && addr_match;

    // Ready and the SRAM port are combinational, so they are forced low
    // while reset is held to keep every output at zero during reset.
    assign tile_qready_o = !rst_i && (state_q == IDLE) && slot_free;
    assign accept        = tile_qvalid_i && tile_qready_o;

    assign tile_pvalid_o  = rsp_valid_q;
    assign tile_pid_o     = rsp_id_q;
    assign tile_perror_o  = rsp_err_q;
    assign tile_plrwait_o = rsp_lrwait_q;
    assign tile_pdata_o   = rsp_rd_q ? mem_rdata_i : rsp_data_q;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        res_valid_d  = res_valid_q;
        res_addr_d   = res_addr_q;
        res_id_d     = res_id_q;
        push         = 1'b0;
        pop          = 1'b0;
        release_res  = 1'b0;
        rsp_load     = 1'b0;
        rsp_id_d     = tile_qid_i;
        rsp_err_d    = 1'b0;
        rsp_lrwait_d = 1'b0;
        rsp_rd_d     = 1'b0;
        rsp_data_d   = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_be_o     = '0;

        if (!rst_i) begin
            if (state_q == WAKE) begin
                // Hand the reservation to the oldest waiter with a fresh read.
                if (slot_free) begin
                    pop          = 1'b1;
                    mem_req_o    = 1'b1;
                    mem_addr_o   = {res_addr_q, 2'b00};
                    res_valid_d  = 1'b1;
                    res_id_d     = wait_q[rd_ptr_q];
                    rsp_load     = 1'b1;
                    rsp_id_d     = wait_q[rd_ptr_q];
                    rsp_lrwait_d = 1'b1;
                    rsp_rd_d     = 1'b1;
                    state_d      = IDLE;
                end
            end else if (accept) begin
                rsp_load = 1'b1;
                case (tile_qamo_i)
                    AmoNone: begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = tile_qwrite_i;
                        mem_addr_o  = tile_qaddr_i;
                        mem_wdata_o = tile_qdata_i;
                        mem_be_o    = tile_qstrb_i;
                        rsp_rd_d    = !tile_qwrite_i;
                        release_res = tile_qwrite_i && res_hit;
                    end
                    AmoLr: begin
                        rsp_lrwait_d = tile_qlrwait_i;
                        if (tile_qlrwait_i && res_valid_q) begin
                            if (addr_match && !q_full) begin
                                // Parked: answered later from WAKE.
                                push     = 1'b1;
                                rsp_load = 1'b0;
                            end else begin
                                rsp_err_d = 1'b1;
                            end
                        end else if (!q_empty) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            mem_req_o   = 1'b1;
                            mem_addr_o  = tile_qaddr_i;
                            rsp_rd_d    = 1'b1;
                            res_valid_d = 1'b1;
                            res_addr_d  = req_word;
                            res_id_d    = tile_qid_i;
                        end
                    end
                    AmoSc: begin
                        if (res_hit && (tile_qid_i == res_id_q)) begin
                            mem_req_o   = 1'b1;
                            mem_we_o    = 1'b1;
                            mem_addr_o  = tile_qaddr_i;
                            mem_wdata_o = tile_qdata_i;
                            mem_be_o    = tile_qstrb_i;
                            release_res = 1'b1;
                        end else begin
                            rsp_data_d = DataWidth'(1);
                        end
                    end
                    default: begin
                        rsp_err_d = 1'b1;
                    end
                endcase
            end
        end

        if (release_res) begin
            res_valid_d = 1'b0;
            if (!q_empty) begin
                state_d = WAKE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
            res_id_q    <= res_id_d;
        end
    end

    // Push and pop are mutually exclusive: push only from IDLE, pop only in WAKE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (push) begin
            wr_ptr_q <= (wr_ptr_q == PtrWidth'(NumWaiters - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            count_q  <= count_q + CntWidth'(1);
        end else if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrWidth'(NumWaiters - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            count_q  <= count_q - CntWidth'(1);
        end
    end

    // NOTE: the waiter storage has no reset; count_q guards every read, so
    // stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            wait_q[wr_ptr_q] <= tile_qid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_err_q    <= 1'b0;
            rsp_lrwait_q <= 1'b0;
            rsp_rd_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else if (rsp_load) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            rsp_lrwait_q <= rsp_lrwait_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_data_q   <= rsp_data_d;
        end else begin
            if (tile_pready_i) begin
                rsp_valid_q <= 1'b0;
            end
            // Read data is only on the bus for one cycle; keep it for stalls.
            if (rsp_rd_q) begin
                rsp_data_q <= mem_rdata_i;
                rsp_rd_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lrwait_bank_node.sv
// tb_lrwait_bank_node
//   Directed scenarios followed by a randomized phase for lrwait_bank_node.
//   Expected responses come from a behavioural model: a word array for the
//   memory, a reservation record and a queue of waiting IDs.
module tb_lrwait_bank_node;

    typedef logic [4:0] id_t;
    localparam int NumWaiters = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] tile_qaddr_i;
    logic        tile_qwrite_i;
    logic [3:0]  tile_qamo_i;
    logic [31:0] tile_qdata_i;
    logic [3:0]  tile_qstrb_i;
    id_t         tile_qid_i;
    logic        tile_qlrwait_i;
    logic        tile_qvalid_i;
    logic        tile_qready_o;
    logic [31:0] tile_pdata_o;
    logic        tile_perror_o;
    id_t         tile_pid_o;
    logic        tile_plrwait_o;
    logic        tile_pvalid_o;
    logic        tile_pready_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    lrwait_bank_node dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .tile_qaddr_i  (tile_qaddr_i),
        .tile_qwrite_i (tile_qwrite_i),
        .tile_qamo_i   (tile_qamo_i),
        .tile_qdata_i  (tile_qdata_i),
        .tile_qstrb_i  (tile_qstrb_i),
        .tile_qid_i    (tile_qid_i),
        .tile_qlrwait_i(tile_qlrwait_i),
        .tile_qvalid_i (tile_qvalid_i),
        .tile_qready_o (tile_qready_o),
        .tile_pdata_o  (tile_pdata_o),
        .tile_perror_o (tile_perror_o),
        .tile_pid_o    (tile_pid_o),
        .tile_plrwait_o(tile_plrwait_o),
        .tile_pvalid_o (tile_pvalid_o),
        .tile_pready_i (tile_pready_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM environment: 1-cycle read latency, byte-enabled writes.
    logic [31:0] sram [256];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) sram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= sram[mem_addr_o[9:2]];
            end
        end
    end

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [256];
    bit          m_res_valid;
    logic [7:0]  m_res_word;
    id_t         m_res_id;
    id_t         m_waitq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_res_valid = 1'b0;
        m_waitq.delete();
    endtask

    // Applies one accepted request to the model and predicts its response.
    task automatic model_req(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                             input logic [31:0] data, input logic [3:0] strb, input id_t id,
                             input logic lrw, output bit has_rsp, output logic [31:0] e_data,
                             output logic e_err, output logic e_lrw, output bit dc_data,
                             output bit wake);
        logic [7:0] w;
        bit hit;
        w = addr[9:2];
        hit = m_res_valid && (m_res_word == w);
        has_rsp = 1; e_data = 0; e_err = 0; e_lrw = 0; dc_data = 0; wake = 0;
        if (amo == 4'h0) begin
            if (wr) begin
                ref_mem[w] = merge(ref_mem[w], data, strb);
                if (hit) begin
                    m_res_valid = 0;
                    wake = (m_waitq.size() > 0);
                end
            end else begin
                e_data = ref_mem[w];
            end
        end else if (amo == 4'hA) begin
            e_lrw = lrw;
            if (lrw && m_res_valid) begin
                if (hit && m_waitq.size() < NumWaiters) begin
                    m_waitq.push_back(id);
                    has_rsp = 0;
                end else begin
                    e_err = 1; dc_data = 1;
                end
            end else if (m_waitq.size() != 0) begin
                e_err = 1; dc_data = 1;
            end else begin
                e_data = ref_mem[w];
                m_res_valid = 1; m_res_word = w; m_res_id = id;
            end
        end else if (amo == 4'hB) begin
            if (hit && id == m_res_id) begin
                ref_mem[w] = merge(ref_mem[w], data, strb);
                m_res_valid = 0;
                wake = (m_waitq.size() > 0);
            end else begin
                e_data = 1;
            end
        end else begin
            e_err = 1; dc_data = 1;
        end
    endtask

    task automatic check_wake(input string tag);
        id_t head;
        @(posedge clk_i); #1;
        head = m_waitq.pop_front();
        m_res_valid = 1;
        m_res_id = head;
        check({tag, "_wake_pvalid"}, 32'(tile_pvalid_o), 1);
        check({tag, "_wake_pid"}, 32'(tile_pid_o), 32'(head));
        check({tag, "_wake_perror"}, 32'(tile_perror_o), 0);
        check({tag, "_wake_plrwait"}, 32'(tile_plrwait_o), 1);
        check({tag, "_wake_pdata"}, tile_pdata_o, ref_mem[m_res_word]);
    endtask

    // Presents one request, waits (bounded) for acceptance, then checks the
    // response against the model, including any wake response that follows.
    task automatic issue(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [3:0] amo, input logic [31:0] data, input logic [3:0] strb,
                         input id_t id, input logic lrw);
        bit has_rsp, dc_data, wake;
        logic [31:0] e_data;
        logic e_err, e_lrw;
        int wait_cycles;
        tile_qaddr_i = addr; tile_qwrite_i = wr; tile_qamo_i = amo; tile_qdata_i = data;
        tile_qstrb_i = strb; tile_qid_i = id; tile_qlrwait_i = lrw; tile_qvalid_i = 1'b1;
        #1;
        wait_cycles = 0;
        while (!tile_qready_o && wait_cycles < 20) begin
            @(posedge clk_i); #1;
            wait_cycles++;
        end
        if (!tile_qready_o) begin
            check({tag, "_accept_timeout"}, 32'(tile_qready_o), 1);
            tile_qvalid_i = 1'b0;
            return;
        end
        model_req(addr, wr, amo, data, strb, id, lrw, has_rsp, e_data, e_err, e_lrw, dc_data, wake);
        @(posedge clk_i); #1;
        tile_qvalid_i = 1'b0;
        check({tag, "_pvalid"}, 32'(tile_pvalid_o), 32'(has_rsp));
        if (has_rsp) begin
            check({tag, "_pid"}, 32'(tile_pid_o), 32'(id));
            check({tag, "_perror"}, 32'(tile_perror_o), 32'(e_err));
            check({tag, "_plrwait"}, 32'(tile_plrwait_o), 32'(e_lrw));
            if (!dc_data) check({tag, "_pdata"}, tile_pdata_o, e_data);
        end
        if (wake) check_wake(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] bases [4] = '{32'h40, 32'h44, 32'h80, 32'h100};

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        mem_rdata_i = '0;
        rst_i = 1'b1;
        tile_qaddr_i = '0; tile_qwrite_i = 0; tile_qamo_i = 0; tile_qdata_i = '0;
        tile_qstrb_i = '0; tile_qid_i = '0; tile_qlrwait_i = 0; tile_qvalid_i = 0;
        tile_pready_i = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_pvalid", 32'(tile_pvalid_o), 0);
        check("rst_qready", 32'(tile_qready_o), 0);
        check("rst_mem_req", 32'(mem_req_o), 0);
        rst_i = 1'b0;
        #1;
        check("post_rst_qready", 32'(tile_qready_o), 1);

        // Store then load back
        issue("st100", 32'h100, 1, 4'h0, 32'hDEADBEEF, 4'hF, 5'd0, 0);
        issue("ld100", 32'h100, 0, 4'h0, 32'h0, 4'h0, 5'd3, 0);
        check("ld100_const", tile_pdata_o, 32'hDEADBEEF);

        // LRWait queueing and hand-over
        issue("lrw1", 32'h40, 0, 4'hA, 0, 0, 5'd1, 1);
        issue("lrw2", 32'h40, 0, 4'hA, 0, 0, 5'd2, 1);
        issue("lrw3", 32'h40, 0, 4'hA, 0, 0, 5'd3, 1);
        issue("sc1", 32'h40, 1, 4'hB, 32'd7, 4'hF, 5'd1, 0);
        issue("sc2", 32'h40, 1, 4'hB, 32'd9, 4'hF, 5'd2, 0);

        // Fill the queue (reservation now held by id 3), then overflow paths
        issue("fill4", 32'h40, 0, 4'hA, 0, 0, 5'd4, 1);
        issue("fill5", 32'h40, 0, 4'hA, 0, 0, 5'd5, 1);
        issue("fill6", 32'h40, 0, 4'hA, 0, 0, 5'd6, 1);
        issue("fill7", 32'h40, 0, 4'hA, 0, 0, 5'd7, 1);
        issue("lrw_full", 32'h40, 0, 4'hA, 0, 0, 5'd8, 1);
        issue("lrw_mismatch", 32'h80, 0, 4'hA, 0, 0, 5'd9, 1);
        issue("lr_busy", 32'h40, 0, 4'hA, 0, 0, 5'd10, 0);
        issue("bad_amo", 32'h40, 0, 4'h3, 0, 0, 5'd11, 0);

        // Failed SC leaves memory alone; plain store releases and wakes
        issue("sc_wrong_id", 32'h40, 1, 4'hB, 32'h55, 4'hF, 5'd5, 0);
        issue("ld40_after_bad_sc", 32'h40, 0, 4'h0, 0, 0, 5'd12, 0);
        issue("st40_release", 32'h40, 1, 4'h0, 32'h1234_5678, 4'h3, 5'd13, 0);
        issue("sc3_stale", 32'h40, 1, 4'hB, 32'h66, 4'hF, 5'd3, 0);
        issue("sc4", 32'h40, 1, 4'hB, 32'h44, 4'hF, 5'd4, 0);
        issue("sc5", 32'h40, 1, 4'hB, 32'h45, 4'hF, 5'd5, 0);
        issue("sc6", 32'h40, 1, 4'hB, 32'h46, 4'hF, 5'd6, 0);
        issue("sc7", 32'h40, 1, 4'hB, 32'h47, 4'hF, 5'd7, 0);

        // Response back-pressure
        @(posedge clk_i); #1;
        tile_pready_i = 1'b0;
        issue("stall_ld", 32'h100, 0, 4'h0, 0, 0, 5'd6, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check("stall_pvalid", 32'(tile_pvalid_o), 1);
            check("stall_pdata", tile_pdata_o, ref_mem[8'h40]);
            check("stall_pid", 32'(tile_pid_o), 6);
            check("stall_qready", 32'(tile_qready_o), 0);
        end
        tile_qaddr_i = 32'h40; tile_qwrite_i = 0; tile_qamo_i = 0; tile_qid_i = 5'd7;
        tile_qlrwait_i = 0; tile_qvalid_i = 1'b1; tile_pready_i = 1'b1;
        #1;
        check("release_qready", 32'(tile_qready_o), 1);
        issue("after_stall_ld", 32'h40, 0, 4'h0, 0, 0, 5'd7, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int r;
            id_t rid;
            a = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            rid = id_t'($urandom_range(0, 31));
            r = $urandom_range(0, 99);
            if (r < 30) begin
                issue("rnd_plain", a, 1'($urandom_range(0, 1)), 4'h0, $urandom,
                      4'($urandom_range(0, 15)), rid, 0);
            end else if (r < 60) begin
                if (m_res_valid && $urandom_range(0, 3) != 0)
                    a = {22'd0, m_res_word, 2'($urandom_range(0, 3))};
                issue("rnd_lr", a, 0, 4'hA, 0, 0, rid, 1'($urandom_range(0, 3) != 0));
            end else if (r < 92) begin
                if (m_res_valid && $urandom_range(0, 3) != 0) a = {22'd0, m_res_word, 2'b00};
                if ($urandom_range(0, 3) != 0) rid = m_res_id;
                issue("rnd_sc", a, 1, 4'hB, $urandom, 4'($urandom_range(0, 15)), rid, 0);
            end else begin
                issue("rnd_bad", a, 0, 4'($urandom_range(1, 9)), 0, 0, rid, 0);
            end
        end

        // Reset mid-operation with waiters queued and a response held
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        model_reset();
        issue("pre_lrw1", 32'h40, 0, 4'hA, 0, 0, 5'd1, 1);
        issue("pre_lrw2", 32'h40, 0, 4'hA, 0, 0, 5'd2, 1);
        issue("pre_lrw3", 32'h40, 0, 4'hA, 0, 0, 5'd3, 1);
        @(posedge clk_i); #1;
        tile_pready_i = 1'b0;
        issue("pre_ld", 32'h100, 0, 4'h0, 0, 0, 5'd9, 0);
        #2;
        tile_qaddr_i = 32'h100; tile_qwrite_i = 1; tile_qamo_i = 0; tile_qdata_i = 32'hFFFF_FFFF;
        tile_qstrb_i = 4'hF; tile_qid_i = 5'd9; tile_qvalid_i = 1'b1;
        rst_i = 1'b1;
        #1;
        check("midrst_pvalid", 32'(tile_pvalid_o), 0);
        check("midrst_qready", 32'(tile_qready_o), 0);
        check("midrst_mem_req", 32'(mem_req_o), 0);
        check("midrst_mem_we", 32'(mem_we_o), 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_mem_wdata", mem_wdata_o, 0);
        check("midrst_mem_be", 32'(mem_be_o), 0);
        check("midrst_pdata", tile_pdata_o, 0);
        check("midrst_pid", 32'(tile_pid_o), 0);
        check("midrst_perror", 32'(tile_perror_o), 0);
        check("midrst_plrwait", 32'(tile_plrwait_o), 0);
        tile_qvalid_i = 1'b0;
        tile_pready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            check("postrst_no_rsp", 32'(tile_pvalid_o), 0);
        end
        issue("postrst_lr4", 32'h40, 0, 4'hA, 0, 0, 5'd4, 0);
        check("postrst_lr4_plrwait", 32'(tile_plrwait_o), 0);
        issue("postrst_sc4", 32'h40, 1, 4'hB, 32'hABCD, 4'hF, 5'd4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
